// File: rtl/instr_register_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_register_pipe_if
// Description : Write/read bus bundle for the pipelined instruction register.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_register_pipe_if #(
    parameter int DEPTH    = 32,
    parameter int OP_WIDTH = 32
) ();
    localparam int AW = $clog2(DEPTH);
    localparam int RW = 2 * OP_WIDTH;

    logic                       load_en;
    logic [AW-1:0]              write_pointer;
    logic [2:0]                 opcode;
    logic signed [OP_WIDTH-1:0] operand_a;
    logic signed [OP_WIDTH-1:0] operand_b;
    logic [AW-1:0]              read_pointer;
    logic [2:0]                 rd_opcode;
    logic signed [OP_WIDTH-1:0] rd_op_a;
    logic signed [OP_WIDTH-1:0] rd_op_b;
    logic signed [RW-1:0]       rd_result;
    logic                       rd_valid;
    logic                       rd_div0;
    logic [AW:0]                valid_count;

    modport master (
        output load_en, write_pointer, opcode, operand_a, operand_b, read_pointer,
        input  rd_opcode, rd_op_a, rd_op_b, rd_result, rd_valid, rd_div0, valid_count
    );

    modport slave (
        input  load_en, write_pointer, opcode, operand_a, operand_b, read_pointer,
        output rd_opcode, rd_op_a, rd_op_b, rd_result, rd_valid, rd_div0, valid_count
    );
endinterface
`default_nettype wire

// File: rtl/instr_register_pipe.sv
`default_nettype none
// ============================================================================
// Module      : instr_register_pipe
// Description : DEPTH-entry instruction register with a two-stage evaluating
//               write pipeline. Define INSTR_REG_BYPASS_EN to forward a
//               same-edge commit onto the read port.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_register_pipe #(
    parameter int DEPTH    = 32,
    parameter int OP_WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    instr_register_pipe_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = 2 * OP_WIDTH;

    typedef enum logic [2:0] {
        OP_ZERO  = 3'd0,
        OP_PASSA = 3'd1,
        OP_PASSB = 3'd2,
        OP_ADD   = 3'd3,
        OP_SUB   = 3'd4,
        OP_MULT  = 3'd5,
        OP_DIV   = 3'd6,
        OP_MOD   = 3'd7
    } opcode_e;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [OP_WIDTH-1:0] op_a;
        logic [OP_WIDTH-1:0] op_b;
        logic [RW-1:0]       result;
        logic                valid;
        logic                div0;
    } entry_t;

    // Stage 1 registers
    logic                       s1_vld_q,    s1_vld_d;
    logic [AW-1:0]              s1_addr_q,   s1_addr_d;
    opcode_e                    s1_opcode_q, s1_opcode_d;
    logic [OP_WIDTH-1:0]        s1_a_q,      s1_a_d;
    logic [OP_WIDTH-1:0]        s1_b_q,      s1_b_d;

    // Storage, read port and occupancy
    entry_t                     entry_q [DEPTH];
    entry_t                     entry_d [DEPTH];
    entry_t                     rd_q,        rd_d;
    logic [AW:0]                valid_count_q, valid_count_d;

    logic signed [RW-1:0]       a_ext;
    logic signed [RW-1:0]       b_ext;
    logic signed [RW-1:0]       commit_result;
    logic                       commit_div0;
    entry_t                     commit_entry;

    always_comb begin
        s1_vld_d    = bus.load_en;
        s1_addr_d   = s1_addr_q;
        s1_opcode_d = s1_opcode_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        if (bus.load_en) begin
            s1_addr_d   = bus.write_pointer;
            s1_opcode_d = opcode_e'(bus.opcode);
            s1_a_d      = bus.operand_a;
            s1_b_d      = bus.operand_b;
        end
    end

    assign a_ext = {{OP_WIDTH{s1_a_q[OP_WIDTH-1]}}, s1_a_q};
    assign b_ext = {{OP_WIDTH{s1_b_q[OP_WIDTH-1]}}, s1_b_q};

    // Zero divisor is trapped here so the divider never sees it
    always_comb begin
        commit_result = '0;
        commit_div0   = 1'b0;
        case (s1_opcode_q)
            OP_ZERO:  commit_result = '0;
            OP_PASSA: commit_result = a_ext;
            OP_PASSB: commit_result = b_ext;
            OP_ADD:   commit_result = a_ext + b_ext;
            OP_SUB:   commit_result = a_ext - b_ext;
            OP_MULT:  commit_result = a_ext * b_ext;
            OP_DIV: begin
                if (b_ext == '0) commit_div0   = 1'b1;
                else             commit_result = a_ext / b_ext;
            end
            OP_MOD: begin
                if (b_ext == '0) commit_div0   = 1'b1;
                else             commit_result = a_ext % b_ext;
            end
            default:  commit_result = '0;
        endcase
    end

    always_comb begin
        commit_entry.opcode = s1_opcode_q;
        commit_entry.op_a   = s1_a_q;
        commit_entry.op_b   = s1_b_q;
        commit_entry.result = commit_result;
        commit_entry.valid  = 1'b1;
        commit_entry.div0   = commit_div0;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            if (s1_vld_q && (s1_addr_q == AW'(i))) begin
                entry_d[i] = commit_entry;
            end
        end
    end

    always_comb begin
        valid_count_d = valid_count_q;
        if (s1_vld_q && !entry_q[s1_addr_q].valid &&
            (valid_count_q != (AW+1)'(DEPTH))) begin
            valid_count_d = valid_count_q + 1'b1;
        end
    end

    always_comb begin
        rd_d = entry_q[bus.read_pointer];
`ifdef INSTR_REG_BYPASS_EN
        if (s1_vld_q && (s1_addr_q == bus.read_pointer)) begin
            rd_d = commit_entry;
        end
`else
        // Pre-commit contents are returned on a same-edge hit
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld_q      <= 1'b0;
            s1_addr_q     <= '0;
            s1_opcode_q   <= OP_ZERO;
            s1_a_q        <= '0;
            s1_b_q        <= '0;
            rd_q          <= '0;
            valid_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            s1_vld_q      <= s1_vld_d;
            s1_addr_q     <= s1_addr_d;
            s1_opcode_q   <= s1_opcode_d;
            s1_a_q        <= s1_a_d;
            s1_b_q        <= s1_b_d;
            rd_q          <= rd_d;
            valid_count_q <= valid_count_d;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    assign bus.rd_opcode   = rd_q.opcode;
    assign bus.rd_op_a     = rd_q.op_a;
    assign bus.rd_op_b     = rd_q.op_b;
    assign bus.rd_result   = rd_q.result;
    assign bus.rd_valid    = rd_q.valid;
    assign bus.rd_div0     = rd_q.div0;
    assign bus.valid_count = valid_count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_register_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_register_pipe
// Description : Directed self-checking bench for instr_register_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_register_pipe;
    localparam int DEPTH    = 32;
    localparam int OP_WIDTH = 32;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    instr_register_pipe_if #(.DEPTH(DEPTH), .OP_WIDTH(OP_WIDTH)) bus ();

    instr_register_pipe #(.DEPTH(DEPTH), .OP_WIDTH(OP_WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [4:0] addr, input logic [2:0] op,
                            input logic signed [31:0] a, input logic signed [31:0] b);
        bus.load_en       = 1'b1;
        bus.write_pointer = addr;
        bus.opcode        = op;
        bus.operand_a     = a;
        bus.operand_b     = b;
        tick();
        bus.load_en       = 1'b0;
    endtask

    // Two edges so the read is valid with or without forwarding
    task automatic do_read(input logic [4:0] addr);
        bus.read_pointer = addr;
        tick();
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n           = 1'b0;
        bus.load_en       = 1'b0;
        bus.write_pointer = '0;
        bus.opcode        = '0;
        bus.operand_a     = '0;
        bus.operand_b     = '0;
        bus.read_pointer  = '0;

        // Reset held for two edges with toggling inputs
        bus.load_en = 1'b1; bus.write_pointer = 5'd3; bus.opcode = 3'd3;
        bus.operand_a = 32'sd9; bus.operand_b = 32'sd1; bus.read_pointer = 5'd3;
        tick();
        bus.write_pointer = 5'd4; bus.opcode = 3'd5; bus.read_pointer = 5'd4;
        tick();
        check("rst_result", bus.rd_result, 64'd0);
        check("rst_opcode", bus.rd_opcode, 3'd0);
        check("rst_op_a",   bus.rd_op_a,   32'd0);
        check("rst_op_b",   bus.rd_op_b,   32'd0);
        check("rst_valid",  bus.rd_valid,  1'b0);
        check("rst_div0",   bus.rd_div0,   1'b0);
        check("rst_count",  bus.valid_count, 6'd0);
        bus.load_en = 1'b0;
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            bus.read_pointer = 5'(i);
            tick();
            check("rst_scan_valid", bus.rd_valid, 1'b0);
        end
        check("rst_scan_count", bus.valid_count, 6'd0);

        // Basic arithmetic
        do_write(5'd0, 3'd3, -32'sd7,  32'sd5);
        do_write(5'd1, 3'd5, -32'sd15, 32'sd15);
        do_write(5'd2, 3'd4, 32'sd3,   32'sd12);
        do_read(5'd0);
        check("add_result", bus.rd_result, -64'sd2);
        check("add_valid",  bus.rd_valid,  1'b1);
        check("add_opcode", bus.rd_opcode, 3'd3);
        check("add_op_a",   bus.rd_op_a,   -32'sd7);
        check("add_op_b",   bus.rd_op_b,   32'sd5);
        do_read(5'd1);
        check("mult_result", bus.rd_result, -64'sd225);
        check("mult_valid",  bus.rd_valid,  1'b1);
        do_read(5'd2);
        check("sub_result", bus.rd_result, -64'sd9);
        check("sub_valid",  bus.rd_valid,  1'b1);
        check("count_3",    bus.valid_count, 6'd3);

        // Division and modulo
        do_write(5'd3, 3'd6, -32'sd15, 32'sd4);
        do_write(5'd4, 3'd7, -32'sd15, 32'sd4);
        do_write(5'd6, 3'd6, 32'sd9,   32'sd0);
        do_read(5'd3);
        check("div_result", bus.rd_result, -64'sd3);
        check("div_div0",   bus.rd_div0,   1'b0);
        do_read(5'd4);
        check("mod_result", bus.rd_result, -64'sd3);
        check("mod_div0",   bus.rd_div0,   1'b0);
        do_read(5'd6);
        check("div0_result", bus.rd_result, 64'd0);
        check("div0_flag",   bus.rd_div0,   1'b1);
        check("div0_valid",  bus.rd_valid,  1'b1);
        check("count_6",     bus.valid_count, 6'd6);

        // Back-to-back overwrite of one entry
        do_write(5'd5, 3'd1, 32'sd4, 32'sd0);
        do_write(5'd5, 3'd2, 32'sd4, 32'sd11);
        do_read(5'd5);
        check("ovw_result", bus.rd_result, 64'sd11);
        check("ovw_opcode", bus.rd_opcode, 3'd2);
        check("ovw_count",  bus.valid_count, 6'd7);

        // Same-edge write/read hazard on entry 7
        bus.load_en = 1'b1; bus.write_pointer = 5'd7; bus.opcode = 3'd3;
        bus.operand_a = 32'sd1; bus.operand_b = 32'sd1;
        tick();
        bus.load_en = 1'b0;
        bus.read_pointer = 5'd7;
        tick();
`ifdef INSTR_REG_BYPASS_EN
        check("haz_first_result", bus.rd_result, 64'sd2);
        check("haz_first_valid",  bus.rd_valid,  1'b1);
`else
        check("haz_first_result", bus.rd_result, 64'd0);
        check("haz_first_valid",  bus.rd_valid,  1'b0);
`endif
        tick();
        check("haz_second_result", bus.rd_result, 64'sd2);
        check("haz_second_valid",  bus.rd_valid,  1'b1);
        check("count_8",           bus.valid_count, 6'd8);

        // Boundary arithmetic
        do_write(5'd9,  3'd5, 32'sh80000000, 32'sh80000000);
        do_write(5'd10, 3'd7, 32'sd5, 32'sd0);
        do_write(5'd11, 3'd6, 32'sd7, -32'sd2);
        do_write(5'd31, 3'd4, -32'sd1, 32'sd2);
        do_read(5'd9);
        check("mult_min_result", bus.rd_result, 64'h4000_0000_0000_0000);
        do_read(5'd10);
        check("mod0_result", bus.rd_result, 64'd0);
        check("mod0_flag",   bus.rd_div0,   1'b1);
        do_read(5'd11);
        check("div_neg_b", bus.rd_result, -64'sd3);
        do_read(5'd31);
        check("top_entry", bus.rd_result, -64'sd3);
        check("count_12",  bus.valid_count, 6'd12);

        // Reset arriving between sample and commit
        bus.load_en = 1'b1; bus.write_pointer = 5'd8; bus.opcode = 3'd1;
        bus.operand_a = 32'sd77; bus.operand_b = 32'sd0;
        tick();
        bus.load_en = 1'b0;
        reset_n = 1'b0;
        #1;
        check("midrst_count_async", bus.valid_count, 6'd0);
        check("midrst_rd_async",    bus.rd_result,   64'd0);
        #2;
        reset_n = 1'b1;
        tick();
        do_read(5'd8);
        check("midrst_valid",  bus.rd_valid,  1'b0);
        check("midrst_result", bus.rd_result, 64'd0);
        check("midrst_count",  bus.valid_count, 6'd0);
        do_read(5'd0);
        check("midrst_entry0", bus.rd_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
